// File: rtl/vram_arbiter.sv
// VRAM arbiter: one single-port frame-buffer RAM shared between VGA pixel fetch
// (absolute priority) and a queued CPU read/write port, all in the vga_clk domain.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 19,
  parameter int DW         = 24
) (
  input  logic          vga_clk,
  input  logic          clr,
  input  logic          vga_rdn,
  input  logic [8:0]    vga_row,
  input  logic [9:0]    vga_col,
  output logic [DW-1:0] vga_d_in,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int STAGES = 2;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGA  = 2'd1;
  localparam logic [1:0] TAG_CRD  = 2'd2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t          fifo [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic          rd_outstanding;
  cmd_t          head;
  logic [1:0]    gnt_tag;
  // stage 1 pairs with mem_rdata, stage 2 is the cycle the result is visible
  logic [STAGES:1][1:0] tag_pipe;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = fifo[rd_ptr[PW-1:0]];

  assign cpu_ready  = !clr && !full && !rd_outstanding;
  assign push       = cpu_req && cpu_ready;
  assign cpu_rvalid = (tag_pipe[2] == TAG_CRD);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = head.addr;
    mem_wdata = head.wdata;
    gnt_tag   = TAG_NONE;
    pop       = 1'b0;
    if (!clr) begin
      if (!vga_rdn) begin
        mem_en   = 1'b1;
        mem_addr = AW'({vga_row, vga_col});
        gnt_tag  = TAG_VGA;
      end else if (!empty) begin
        mem_en  = 1'b1;
        mem_we  = head.we;
        pop     = 1'b1;
        gnt_tag = head.we ? TAG_NONE : TAG_CRD;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  end

  always_ff @(posedge vga_clk) begin
    if (clr) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_outstanding <= 1'b0;
      tag_pipe       <= '0;
      vga_d_in       <= '0;
      cpu_rdata      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      tag_pipe <= {tag_pipe[1], gnt_tag};
      if (tag_pipe[1] == TAG_VGA) vga_d_in  <= mem_rdata;
      if (tag_pipe[1] == TAG_CRD) cpu_rdata <= mem_rdata;
      // reads block the port until their data returns; writes are posted
      if (push && !cpu_we)              rd_outstanding <= 1'b1;
      else if (tag_pipe[1] == TAG_CRD)  rd_outstanding <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vram_arbiter;
  localparam int AW = 19, DW = 24, DEPTH = 4;

  logic          clk = 1'b0;
  logic          clr, vga_rdn, cpu_req, cpu_we, cpu_ready, cpu_rvalid;
  logic          mem_en, mem_we, preload, go;
  logic [8:0]    vga_row;
  logic [9:0]    vga_col;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, vga_d_in, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  int            n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.FIFO_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .vga_clk(clk), .clr(clr), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
    .vga_d_in(vga_d_in), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // frame-buffer RAM
  bit [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (preload) ram[19'h00C05] <= 24'h55aaff;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // reference model
  typedef struct { bit we; bit [AW-1:0] addr; bit [DW-1:0] wdata; } cmd_t;
  cmd_t        mq[$];
  bit [DW-1:0] mm [0:(1<<AW)-1];
  bit          m_rd_out, m_rv;
  bit [DW-1:0] m_vga, m_rd, ev_data;
  int          ev_kind;

  function automatic bit m_ready();
    return (clr === 1'b0) && (mq.size() < DEPTH) && !m_rd_out;
  endfunction

  // kind: 0 idle, 1 vga, 2 cpu read, 3 cpu write
  function automatic void exp_grant(output bit en, output bit we, output bit [AW-1:0] a,
                                    output bit [DW-1:0] wd, output int k);
    en = 0; we = 0; a = '0; wd = '0; k = 0;
    if (clr !== 1'b0) return;
    if (!vga_rdn) begin
      en = 1; a = {vga_row, vga_col}; k = 1;
    end else if (mq.size() > 0) begin
      en = 1; we = mq[0].we; a = mq[0].addr; wd = mq[0].wdata; k = we ? 3 : 2;
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit en, we, rdy;
    bit [AW-1:0] a;
    bit [DW-1:0] wd, rv;
    int k;
    if (clr) begin
      mq.delete(); m_rd_out = 0; m_vga = '0; m_rd = '0; m_rv = 0; ev_kind = 0;
      if (preload) mm[19'h00C05] = 24'h55aaff;
    end else begin
      rdy = m_ready();
      exp_grant(en, we, a, wd, k);
      rv = mm[a];
      m_rv = 0;
      if (ev_kind == 1) m_vga = ev_data;
      else if (ev_kind == 2) begin m_rv = 1; m_rd = ev_data; m_rd_out = 0; end
      ev_kind = k; ev_data = rv;
      if (k == 3) mm[a] = wd;
      if (k >= 2) void'(mq.pop_front());
      if (cpu_req && rdy) begin
        mq.push_back('{cpu_we, cpu_addr, cpu_wdata});
        if (!cpu_we) m_rd_out = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit en, we;
    bit [AW-1:0] a;
    bit [DW-1:0] wd;
    int k;
    if (go) begin
      exp_grant(en, we, a, wd, k);
      chk("mem_en", mem_en, en);
      chk("mem_we", mem_we, we);
      if (en) chk("mem_addr", mem_addr, a);
      if (en && we) chk("mem_wdata", mem_wdata, wd);
      chk("cpu_ready", cpu_ready, m_ready());
      chk("vga_d_in", vga_d_in, m_vga);
      chk("cpu_rvalid", cpu_rvalid, m_rv);
      if (m_rv) chk("cpu_rdata", cpu_rdata, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cpu(bit req, bit we, bit [AW-1:0] a, bit [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    int nwe;
    go = 0; clr = 1; preload = 1; vga_rdn = 1; vga_row = '0; vga_col = '0;
    set_cpu(1, 1, 19'h7, 24'h777);
    // reset with a pending request
    tick(); go = 1;
    #1 chk("rst_ready", cpu_ready, 0); chk("rst_mem_en", mem_en, 0); chk("rst_vga_d", vga_d_in, 0);
    tick();
    #1 chk("rst_ready2", cpu_ready, 0); chk("rst_mem_en2", mem_en, 0);
    clr = 0; preload = 0; set_cpu(0, 0, '0, '0);
    #1 chk("post_rst_ready", cpu_ready, 1); chk("post_rst_en", mem_en, 0);
    tick();

    // VGA fetch
    vga_rdn = 0; vga_row = 9'd3; vga_col = 10'd5;
    #1 chk("vga_addr", mem_addr, 19'h00C05); chk("vga_we", mem_we, 0); chk("vga_en", mem_en, 1);
    tick(); vga_rdn = 1;
    tick();
    #1 chk("vga_pixel", vga_d_in, 24'h55aaff);

    // posted writes while display holds the RAM
    vga_rdn = 0; vga_row = '0; vga_col = '0;
    for (int i = 0; i < 4; i++) begin
      set_cpu(1, 1, AW'(i), DW'(i + 1));
      #1 chk("fill_ready", cpu_ready, 1);
      tick();
    end
    set_cpu(1, 1, 19'h4, 24'h5);
    #1 chk("full_ready", cpu_ready, 0); chk("full_we", mem_we, 0);
    tick(); tick();
    set_cpu(0, 0, '0, '0); vga_rdn = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("drain_we", mem_we, 1); chk("drain_addr", mem_addr, k); chk("drain_data", mem_wdata, k + 1);
      if (k == 0) chk("drain_ready0", cpu_ready, 0);
      if (k == 1) chk("drain_ready1", cpu_ready, 1);
      tick();
    end
    #1 chk("drain_done", mem_we, 0);

    // read after write
    set_cpu(1, 1, 19'h10, 24'h123456); tick();
    set_cpu(1, 0, 19'h10, '0);
    #1 chk("raw_rd_ready", cpu_ready, 1);
    tick(); set_cpu(0, 0, '0, '0);
    #1 chk("raw_busy0", cpu_ready, 0); chk("raw_rv0", cpu_rvalid, 0); chk("raw_rd_en", mem_en, 1);
    tick();
    #1 chk("raw_busy1", cpu_ready, 0); chk("raw_rv1", cpu_rvalid, 0);
    tick();
    #1 chk("raw_rv", cpu_rvalid, 1); chk("raw_data", cpu_rdata, 24'h123456); chk("raw_ready", cpu_ready, 1);
    tick();
    #1 chk("raw_rv_end", cpu_rvalid, 0);

    // collision: VGA takes the cycle the head would have popped
    set_cpu(1, 1, 19'h20, 24'habcdef); tick();
    set_cpu(0, 0, '0, '0); vga_rdn = 0; vga_row = 9'd1; vga_col = 10'd2;
    #1 chk("col_we", mem_we, 0); chk("col_addr", mem_addr, 19'h00402);
    tick(); vga_rdn = 1;
    #1 chk("col_pop_we", mem_we, 1); chk("col_pop_addr", mem_addr, 19'h20); chk("col_pop_d", mem_wdata, 24'habcdef);
    tick();
    #1 chk("col_idle", mem_en, 0);

    // reset discards queued writes
    vga_rdn = 0; vga_row = '0; vga_col = '0;
    for (int i = 0; i < 3; i++) begin
      set_cpu(1, 1, AW'(19'h30 + i), DW'(24'h900 + i));
      tick();
    end
    set_cpu(0, 0, '0, '0); clr = 1;
    tick(); clr = 0; vga_rdn = 1;
    nwe = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (mem_we) nwe++;
      tick();
    end
    chk("mid_rst_we", nwe, 0);
    chk("mid_rst_ready", cpu_ready, 1);
    set_cpu(1, 0, 19'h30, '0); tick();
    set_cpu(0, 0, '0, '0); tick(); tick();
    #1 chk("mid_rst_rv", cpu_rvalid, 1); chk("mid_rst_data", cpu_rdata, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (24-bit pixels, 19-bit address) between the VGA display controller's pixel fetch and a CPU read/write port.
- VGA fetches have absolute priority, because the display cannot stall.
- CPU accesses are queued in a small command FIFO and drain in free cycles, mainly during horizontal and vertical blanking.
- Sits between vgac (row/col/rdn in, d_in out) and the frame-buffer RAM, in the vga_clk domain.

Parameters:
- FIFO_DEPTH, 4, CPU command FIFO entries; power of 2, minimum 2.
- AW, 19, RAM address width; equals row width + col width (9 + 10).
- DW, 24, pixel/data width.

Ports:
- vga_clk  in  1  clock; all logic on rising edge.
- clr  in  1  synchronous active-high reset.
- vga_rdn  in  1  VGA read request, active low (vgac rdn).
- vga_row  in  9  VGA row address.
- vga_col  in  10  VGA column address.
- vga_d_in  out  DW  pixel data returned to vgac.
- cpu_req  in  1  CPU command valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ready  out  1  command accepted this cycle if cpu_req=1.
- cpu_rdata  out  DW  CPU read data.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; valid the cycle after a read with mem_en=1.

Behaviour:
- Reset (clr=1 at an edge):
  - FIFO emptied; rd_outstanding=0; grant pipeline cleared.
  - vga_d_in=0, cpu_rdata=0, cpu_rvalid=0, cpu_ready=0 while clr=1.
  - mem_en=0 and mem_we=0 combinationally while clr=1.
- Accept: a CPU command {we,addr,wdata} is pushed when cpu_req && cpu_ready.
  - cpu_ready = !clr && !fifo_full && !rd_outstanding.
  - Accepting a read sets rd_outstanding. It clears on the cpu_rvalid edge, so reads are blocking and writes are posted.
  - No full-bypass: when full, cpu_ready=0 even if a pop occurs in the same cycle.
- Grant, combinational per cycle, with the following priority:
  1. GNT_VGA: vga_rdn=0 -> mem_en=1, mem_we=0, mem_addr={vga_row,vga_col}.
  2. GNT_CPU: else, FIFO non-empty -> pop head; mem_en=1, mem_we=head.we, mem_addr=head.addr, mem_wdata=head.wdata.
  3. GNT_NONE: else mem_en=0, mem_we=0; mem_addr and mem_wdata hold the FIFO head value (don't-care).
- No bypass from cpu_req to the RAM: the earliest RAM access for an accepted command is the next cycle.
- A push and a pop in the same cycle are both honoured; count is unchanged.
- Return pipeline:
  - A 2-stage tag register records {GNT_VGA | GNT_CPU_READ | other}.
  - At edge t+1 after a grant in cycle t, mem_rdata is valid during cycle t+1.
  - At edge t+2, vga_d_in <= mem_rdata for a VGA tag. vga_d_in holds its value otherwise.
  - At edge t+2, cpu_rdata <= mem_rdata and cpu_rvalid=1 for one cycle for a CPU-read tag.
  - Total latency: VGA address to vga_d_in, and CPU read grant to cpu_rvalid, are both exactly 2 cycles.
- Ordering: CPU commands execute in acceptance order. A read after a write to the same address returns the new data.
- Starvation: the CPU may wait indefinitely while vga_rdn=0. The design relies on blanking (160 of 800 cycles per line) for drain.
- Reset mid-operation: queued commands are discarded (never written). An in-flight read produces no cpu_rvalid. Tags are cleared.
- No range check on vga_row/vga_col. vgac deasserts rdn outside the 640x480 region.

Test Plan:
- Reset: clr=1 for 2 cycles with cpu_req=1 -> cpu_ready=0, mem_en=0, vga_d_in=0. After release, cpu_ready=1 with an empty FIFO.
- VGA fetch: RAM[19'h00C05]=24'h55aaff; vga_rdn=0, row=3, col=5 at cycle t -> mem_addr=19'h00C05, mem_we=0 in t; vga_d_in=24'h55aaff after edge t+2.
- Posted writes during display: vga_rdn=0 held; 4 writes (addr 0..3, data 24'h000001..24'h000004) accepted.
  - 5th cpu_req sees cpu_ready=0; mem_we stays 0.
  - vga_rdn -> 1: mem_we=1 for 4 consecutive cycles, in order.
  - cpu_ready returns to 1 after the first pop.
- Read-after-write: write 24'h123456 to 19'h00010, then read 19'h00010, vga_rdn=1 -> cpu_rvalid pulses once with cpu_rdata=24'h123456. cpu_ready=0 from read accept until the rvalid edge.
- Collision: FIFO head pending; vga_rdn falls in that cycle -> VGA granted, head not popped; head pops in the first cycle with vga_rdn=1.
- Mid-operation reset: 3 writes queued under vga_rdn=0; clr pulsed 1 cycle; vga_rdn -> 1 -> no mem_we ever asserts, and FIFO empty (cpu_ready=1).
